// File: rtl/ls148_pkg.sv
// ---------------------------------------------------------------------------
// ls148_pkg
// Shared types and helpers for the LS148-style request encoder.
//   REQ_W        : number of request lines (8)
//   CODE_W       : width of the granted index (3)
//   ls148_state_t: grant FSM states IDLE / HOLD / GAP
//   prio_index() : index of the highest set bit (bit 7 = highest priority)
// ---------------------------------------------------------------------------
package ls148_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } ls148_state_t;

  // Ascending scan so that the last set bit seen (the highest) wins.
  function automatic logic [CODE_W-1:0] prio_index(input logic [REQ_W-1:0] vec);
    logic [CODE_W-1:0] res;
    res = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (vec[i]) res = CODE_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/ls148_req_encoder_if.sv
// ---------------------------------------------------------------------------
// ls148_req_encoder_if
// Valid/ready code bus between the encoder (master) and its consumer (slave).
//   valid : code is offered and held stable until accepted
//   ready : consumer accepts the code when valid & ready
//   code  : binary index of the granted request
// ---------------------------------------------------------------------------
interface ls148_req_encoder_if;
  import ls148_pkg::*;

  logic              valid;
  logic              ready;
  logic [CODE_W-1:0] code;

  modport master (output valid, output code, input ready);
  modport slave  (input valid, input code, output ready);

endinterface

// File: rtl/ls148_core.sv
// ---------------------------------------------------------------------------
// ls148_core
// Purely combinational 8:3 priority encoder.
//   pending : request vector, bit 7 has the highest priority
//   idx     : index of the highest set bit (0 when nothing is set)
//   any     : at least one bit of pending is set
// ---------------------------------------------------------------------------
module ls148_core
  import ls148_pkg::*;
(
  input  logic [REQ_W-1:0]  pending,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  assign idx = prio_index(pending);
  assign any = |pending;

endmodule

// File: rtl/ls148_req_encoder.sv
// ---------------------------------------------------------------------------
// ls148_req_encoder
// Clocked 74LS148-style 8:3 priority encoder. Falling edges on the
// asynchronous active-low request lines are synchronized, captured into a
// pending register, and the highest pending index is offered on a
// valid/ready bus. A served request is cleared from pending on handshake.
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset
//   ei_n   : active-low enable; high blocks capture and new grants
//   req_n  : asynchronous active-low request lines
//   bus    : valid/ready/code handshake (master side)
//   gs_n   : group select, always the inverse of valid
//   eo_n   : registered enable-out, low when enabled, idle and nothing pending
//   ovf    : one-cycle pulse when a request edge hits an already pending bit
//
// Parameter
//   SYNC_STAGES : synchronizer depth on each req_n bit, legal range 2..4.
//                 Request-to-valid latency is SYNC_STAGES+2 rising edges.
// ---------------------------------------------------------------------------
module ls148_req_encoder
  import ls148_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ei_n,
  input  logic [REQ_W-1:0]     req_n,
  ls148_req_encoder_if.master  bus,
  output logic                 gs_n,
  output logic                 eo_n,
  output logic                 ovf
);

  // -------------------------------------------------------------------------
  // Synchronizer and edge history. Both reset to all-ones (inactive) so that
  // a line held low across reset produces a fresh falling edge afterwards.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][REQ_W-1:0] sync_q;
  logic [REQ_W-1:0]                  prev_q;
  logic [REQ_W-1:0]                  req_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_n};
      prev_q <= req_s;
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Per-bit 1-to-0 detection on the synchronized lines.
  logic [REQ_W-1:0] fall_w;

  genvar gi;
  generate
    for (gi = 0; gi < REQ_W; gi++) begin : g_edge
      assign fall_w[gi] = prev_q[gi] & ~req_s[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Pending register, clear-on-handshake and overflow detection.
  // -------------------------------------------------------------------------
  logic [REQ_W-1:0]  pending_q, pending_d;
  logic [REQ_W-1:0]  set_w, clr_w;
  logic              ovf_q, ovf_d;
  logic              eo_n_q, eo_n_d;
  logic              hs_w;

  ls148_state_t      state_q;
  logic              valid_q;
  logic [CODE_W-1:0] code_q;

  logic [CODE_W-1:0] idx_w;
  logic              any_w;

  ls148_core u_core (
    .pending (pending_q),
    .idx     (idx_w),
    .any     (any_w)
  );

  // Edges seen while disabled are dropped outright; they never overflow.
  assign set_w = ei_n ? '0 : fall_w;
  assign hs_w  = valid_q & bus.ready;
  assign clr_w = hs_w ? (REQ_W'(1) << code_q) : '0;

  always_comb begin
    // Set is applied after clear, so a new edge on the bit being served
    // keeps it pending; it is excluded from overflow for the same reason.
    pending_d = (pending_q & ~clr_w) | set_w;
    ovf_d     = |(set_w & pending_q & ~clr_w);
    eo_n_d    = ~(~ei_n & ~any_w & (state_q == IDLE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
      eo_n_q    <= 1'b1;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      eo_n_q    <= eo_n_d;
    end
  end

  // -------------------------------------------------------------------------
  // Grant FSM. Priority is sampled only when leaving IDLE; once offered, the
  // code is held until accepted even if ei_n rises or a higher request lands.
  // GAP forces at least one idle cycle between consecutive grants.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ei_n && any_w) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            code_q  <= idx_w;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            state_q <= GAP;
            valid_q <= 1'b0;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.code  = code_q;
  assign gs_n      = ~valid_q;
  assign eo_n      = eo_n_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ls148_req_encoder.sv
// ---------------------------------------------------------------------------
// tb_ls148_req_encoder
// Directed scenarios followed by a randomized run, all checked every cycle
// against a behavioural model built from request history and a pending set.
// ---------------------------------------------------------------------------
module tb_ls148_req_encoder;

  localparam int S = 2;

  logic       clk;
  logic       rst_n;
  logic       ei_n;
  logic [7:0] req_n;
  logic       gs_n;
  logic       eo_n;
  logic       ovf;

  ls148_req_encoder_if bus_if ();

  ls148_req_encoder #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ei_n  (ei_n),
    .req_n (req_n),
    .bus   (bus_if),
    .gs_n  (gs_n),
    .eo_n  (eo_n),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model state ----------------
  // m_hist[0] is the newest sample of req_n; m_hist[S-1] is what the design
  // currently treats as the line level and m_hist[S] the level before it.
  logic [7:0] m_hist [0:S];
  logic [7:0] m_pend;
  int         m_phase;   // 0 waiting, 1 offering, 2 cool-down cycle
  logic       m_valid;
  logic [2:0] m_code;
  logic       m_eo_n;
  logic       m_ovf;

  task automatic model_reset();
    for (int k = 0; k <= S; k++) m_hist[k] = 8'hFF;
    m_pend  = 8'h00;
    m_phase = 0;
    m_valid = 1'b0;
    m_code  = 3'd0;
    m_eo_n  = 1'b1;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] fell, newly, served;
    int hi;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fell = m_hist[S] & ~m_hist[S-1];
    for (int k = S; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = req_n;
    served = (m_valid && bus_if.ready) ? (8'h01 << m_code) : 8'h00;
    newly  = ei_n ? 8'h00 : fell;
    m_ovf  = |(newly & m_pend & ~served);
    m_eo_n = !(!ei_n && m_pend == 8'h00 && m_phase == 0);
    if (m_phase == 0) begin
      if (!ei_n && m_pend != 8'h00) begin
        hi = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) hi = i;
        m_code  = 3'(hi);
        m_valid = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus_if.ready) begin
        m_valid = 1'b0;
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~served) | newly;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {7'd0, bus_if.valid}, {7'd0, m_valid});
    chk({tag, ".gs_n"},  {7'd0, gs_n},         {7'd0, ~m_valid});
    chk({tag, ".eo_n"},  {7'd0, eo_n},         {7'd0, m_eo_n});
    chk({tag, ".ovf"},   {7'd0, ovf},          {7'd0, m_ovf});
    chk({tag, ".code"},  {5'd0, bus_if.code},  {5'd0, m_code});
  endtask

  // One clock: advance model at the edge, compare 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  int ovf_cnt;
  int valid_cnt;
  int grant_t [$];
  logic [2:0] grant_c [$];

  initial begin
    rst_n = 1'b0;
    ei_n  = 1'b0;
    req_n = 8'hFF;
    bus_if.ready = 1'b0;
    model_reset();

    // ---- reset ----
    step("rst");
    step("rst");
    chk("rst.valid", {7'd0, bus_if.valid}, 8'h00);
    chk("rst.code",  {5'd0, bus_if.code},  8'h00);
    chk("rst.gs_n",  {7'd0, gs_n},         8'h01);
    chk("rst.eo_n",  {7'd0, eo_n},         8'h01);
    chk("rst.ovf",   {7'd0, ovf},          8'h00);

    // ---- quiet lines: no grant, eo_n low ----
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("idle");
      chk("idle.valid", {7'd0, bus_if.valid}, 8'h00);
      chk("idle.eo_n",  {7'd0, eo_n},         8'h00);
      chk("idle.ovf",   {7'd0, ovf},          8'h00);
    end

    // ---- single request, latency S+2, held until ready ----
    req_n[5] = 1'b0;
    for (int e = 1; e <= S + 1; e++) begin
      step("lat");
      chk("lat.early_valid", {7'd0, bus_if.valid}, 8'h00);
    end
    step("lat");
    chk("lat.valid", {7'd0, bus_if.valid}, 8'h01);
    chk("lat.code",  {5'd0, bus_if.code},  8'h05);
    for (int i = 0; i < 20; i++) begin
      step("hold");
      chk("hold.code", {5'd0, bus_if.code}, 8'h05);
    end
    bus_if.ready = 1'b1;
    step("ack");
    chk("ack.valid", {7'd0, bus_if.valid}, 8'h00);
    bus_if.ready = 1'b0;
    step("gap");
    step("gap");
    chk("after_gap.eo_n", {7'd0, eo_n}, 8'h00);
    req_n[5] = 1'b1;
    for (int i = 0; i < 4; i++) step("rel5");

    // ---- two simultaneous requests, ready held high ----
    bus_if.ready = 1'b1;
    req_n[2] = 1'b0;
    req_n[6] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step("pair");
      if (bus_if.valid) begin
        grant_t.push_back(t);
        grant_c.push_back(bus_if.code);
      end
    end
    chk("pair.count", 8'(grant_c.size()), 8'd2);
    if (grant_c.size() == 2) begin
      chk("pair.first",  {5'd0, grant_c[0]}, 8'h06);
      chk("pair.second", {5'd0, grant_c[1]}, 8'h02);
      chk("pair.gap_ok", {7'd0, (grant_t[1] - grant_t[0]) >= 2}, 8'h01);
    end
    req_n = 8'hFF;
    bus_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) step("relpair");

    // ---- edge while disabled is discarded ----
    ei_n = 1'b1;
    req_n[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step("dis");
      chk("dis.eo_n",  {7'd0, eo_n},         8'h01);
      chk("dis.valid", {7'd0, bus_if.valid}, 8'h00);
    end
    ei_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step("reen");
      chk("reen.valid", {7'd0, bus_if.valid}, 8'h00);
    end
    req_n[3] = 1'b1;
    for (int i = 0; i < 3; i++) step("tog3");
    req_n[3] = 1'b0;
    for (int i = 0; i < 10 && !bus_if.valid; i++) step("wait3");
    chk("grant3.valid", {7'd0, bus_if.valid}, 8'h01);
    chk("grant3.code",  {5'd0, bus_if.code},  8'h03);
    bus_if.ready = 1'b1;
    step("ack3");
    bus_if.ready = 1'b0;
    req_n[3] = 1'b1;
    for (int i = 0; i < 4; i++) step("rel3");

    // ---- overflow on an already pending bit ----
    req_n[4] = 1'b0;
    for (int i = 0; i < 10 && !bus_if.valid; i++) step("wait4");
    chk("grant4.code", {5'd0, bus_if.code}, 8'h04);
    req_n[4] = 1'b1;
    step("pulse4");
    step("pulse4");
    req_n[4] = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step("ovfwin");
      if (ovf) ovf_cnt++;
    end
    chk("ovf.pulses", 8'(ovf_cnt), 8'd1);
    bus_if.ready = 1'b1;
    step("ack4");
    bus_if.ready = 1'b0;
    valid_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step("post4");
      if (bus_if.valid) valid_cnt++;
    end
    chk("ovf.merged", 8'(valid_cnt), 8'd0);
    req_n[4] = 1'b1;
    for (int i = 0; i < 4; i++) step("rel4");

    // ---- reset during HOLD with the line still low ----
    req_n[7] = 1'b0;
    for (int i = 0; i < 10 && !bus_if.valid; i++) step("wait7");
    chk("grant7.code", {5'd0, bus_if.code}, 8'h07);
    rst_n = 1'b0;
    step("midrst");
    chk("midrst.valid", {7'd0, bus_if.valid}, 8'h00);
    rst_n = 1'b1;
    for (int e = 1; e <= S + 1; e++) begin
      step("rearm");
      chk("rearm.early_valid", {7'd0, bus_if.valid}, 8'h00);
    end
    step("rearm");
    chk("rearm.valid", {7'd0, bus_if.valid}, 8'h01);
    chk("rearm.code",  {5'd0, bus_if.code},  8'h07);
    bus_if.ready = 1'b1;
    step("ack7");
    bus_if.ready = 1'b0;
    req_n[7] = 1'b1;
    for (int i = 0; i < 4; i++) step("rel7");

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req_n[$urandom_range(0, 7)] ^= 1'b1;
      ei_n = ($urandom_range(0, 9) == 0);
      bus_if.ready = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ls148_req_encoder.md
Name: ls148_req_encoder

Overview:
- Clocked 8-to-3 priority encoder in the 74LS148 style; the inverse of the team's LS138 3-to-8 decoder.
- Captures falling edges on eight active-low request lines into a pending register and presents the highest pending index (7 = highest priority) as a 3-bit code.
- Uses a valid/ready handshake and clears each request once it has been served.
- Sits between lab-board switches/LS138-style active-low sources and the downstream logic that consumes the codes.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each req_n bit; legal range 2..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ei_n  input  1  enable input, active-low; high blocks capture of new requests and blocks new grants.
- req_n  input  8  asynchronous active-low request lines.
- ready  input  1  consumer accepts the code when valid=1 and ready=1.
- valid  output  1  code is valid and held.
- code  output  3  binary index of the granted request.
- gs_n  output  1  group select, active-low; equals ~valid.
- eo_n  output  1  enable output for cascading, active-low.
- ovf  output  1  one-cycle pulse when a request is lost.

Behaviour:
- Reset (rst_n sampled low at a clk edge):
  - valid=0, code=3'b000, gs_n=1, eo_n=1, ovf=0, pending=8'h00, FSM=IDLE.
  - Synchronizer and edge-history flops all load 1 (inactive).
  - Consequence: a req_n held low across reset is seen as a new event after reset.
- Synchronize: req_n passes through SYNC_STAGES flops to give req_s.
- Edge detect:
  - prev <= req_s every cycle.
  - edge[i] = prev[i] & ~req_s[i] (a 1-to-0 transition).
- Capture: edge[i] sets pending[i] only when ei_n=0 in that cycle; otherwise the edge is discarded, with no ovf pulse.
- Overflow: if edge[i] hits a bit that is already pending and not being cleared that cycle:
  - ovf=1 for exactly one cycle;
  - pending is unchanged (the event merges).
- Clear: a handshake (valid & ready) clears pending[code].
  - If edge[code] arrives in the same cycle, the set wins: the bit stays pending and ovf=0.
- FSM, with registered outputs:
  - IDLE: if ei_n=0 and pending!=0, then next state is HOLD, code <= index of the highest set pending bit, valid <= 1.
  - HOLD: valid=1 and code held stable. On ready=1: perform the clear, valid <= 0, next state is GAP. If ei_n rises while in HOLD, valid stays high until ready; the offer is never withdrawn.
  - GAP: one cycle with valid=0, then IDLE. This guarantees back-to-back grants are separated by at least one cycle.
- Latency with SYNC_STAGES=2: valid rises at the 4th rising edge, counting the first edge that samples req_n[i] low as edge 1. In general the latency is SYNC_STAGES+2 edges.
- Priority is evaluated when IDLE commits. A higher request arriving during HOLD does not pre-empt the current grant; it is served on the next pass.
- eo_n (registered):
  - 0 when ei_n=0, pending==0 and FSM=IDLE;
  - otherwise 1.
- code is don't-care when valid=0, but the register holds its last value.
- Reset mid-HOLD: valid drops at the reset edge; the un-acknowledged request is lost.

Decomposition:
- Package ls148_pkg holds:
  - typedef enum logic [1:0] {IDLE, HOLD, GAP} ls148_state_t;
  - localparam REQ_W = 8 and CODE_W = 3;
  - function prio_index(logic [7:0]) returning logic [2:0].
- Sub-module ls148_core: purely combinational 8:3 priority encoder.
  - Inputs: pending[7:0].
  - Outputs: idx[2:0] and any (pending != 0).
  - Instantiated once by ls148_req_encoder.

Test Plan:
- Reset, then req_n=8'hFF with ei_n=0 for 10 cycles -> valid=0, gs_n=1, eo_n=0, ovf never 1.
- req_n[5] driven low at cycle 0 with ready=0 -> valid=1 and code=3'd5 at edge 4; held stable for 20 cycles; ready=1 for one cycle -> valid=0 next edge; pending=0; eo_n=0 after GAP.
- req_n[2] and req_n[6] fall in the same cycle, ready=1 constant -> grants code=6, then GAP, then code=2; no ovf.
- ei_n=1 while req_n[3] falls, then ei_n=0 -> no grant (the edge is discarded) and eo_n=1 while ei_n=1; req_n[3] toggled high then low -> grant code=3.
- With bit 4 pending and ready=0, pulse req_n[4] high then low -> ovf=1 for exactly one cycle; after ack, a single grant only.
- rst_n low for one edge during HOLD (code=7) while req_n[7] remains low -> valid=0 at that edge; after release, the held-low line is seen as a new event and code=7 is granted again SYNC_STAGES+2 edges later.
